// File: rtl/dft_spi_result_tx.sv
// SPI-slave (mode 0) transmitter that snapshots DFT bin results and shifts them out on MISO.
// SS/SCLK are oversampled in the system clock domain.
module dft_spi_result_tx #(
  parameter int unsigned SPI_WIDTH = 8,
  parameter int unsigned DFT_WIDTH = 12,
  parameter int unsigned BIN_NUM   = 1
) (
  input  logic                                   i_sys_clk,
  input  logic                                   i_sys_rst,
  input  logic [BIN_NUM-1:0][1:0][DFT_WIDTH-1:0] i_X,
  input  logic                                   i_done,
  input  logic                                   i_ss,
  input  logic                                   i_sclk,
  output logic                                   o_miso,
  output logic                                   o_frame_valid,
  output logic                                   o_busy,
  output logic                                   o_overrun
);

  localparam int unsigned FrameBytes = 1 + 4 * BIN_NUM;
  localparam int unsigned PayBytes   = 4 * BIN_NUM;
  localparam int unsigned IdxW       = $clog2(FrameBytes + 1);
  localparam int unsigned BitW       = $clog2(SPI_WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameBytes);
  localparam logic [BitW-1:0] LastBit = BitW'(SPI_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                                 state_q, state_d;
  logic [7:0]                             shift_q, shift_d;
  logic [BitW-1:0]                        bit_cnt_q, bit_cnt_d;
  logic [IdxW-1:0]                        byte_idx_q, byte_idx_d;
  logic [BIN_NUM-1:0][1:0][DFT_WIDTH-1:0] buf_q, buf_d;
  logic                                   valid_q, valid_d;
  logic                                   overrun_q, overrun_d;
  logic [5:0]                             cnt_q, cnt_d;

  logic ss_meta_q, ss_sync_q, ss_hist_q;
  logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
  logic ss_fall, ss_rise, sclk_fall;

  logic            snap;
  logic [7:0]      status_byte;
  logic [7:0]      payload [PayBytes];
  logic [IdxW-1:0] load_idx;
  logic [7:0]      next_byte;

  // Synchronisers reset low so an SS held low across reset cannot start a transaction.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_hist_q   <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_hist_q <= 1'b0;
    end else begin
      ss_meta_q   <= i_ss;
      ss_sync_q   <= ss_meta_q;
      ss_hist_q   <= ss_sync_q;
      sclk_meta_q <= i_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_hist_q <= sclk_sync_q;
    end
  end

  assign ss_fall   = ~ss_sync_q & ss_hist_q;
  assign ss_rise   = ss_sync_q & ~ss_hist_q;
  assign sclk_fall = ~sclk_sync_q & sclk_hist_q;

  function automatic logic [7:0] sext_byte(input logic [DFT_WIDTH-1:0] v, input logic hi);
    logic [15:0] w;
    w = 16'($signed(v));
    return hi ? w[15:8] : w[7:0];
  endfunction

  always_comb begin
    for (int unsigned b = 0; b < BIN_NUM; b++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        payload[4 * b + 2 * c]     = sext_byte(buf_q[b][c], 1'b1);
        payload[4 * b + 2 * c + 1] = sext_byte(buf_q[b][c], 1'b0);
      end
    end
  end

  // Status reflects a snapshot taken in the same cycle as the SS fall.
  assign snap        = i_done && (state_q == StIdle);
  assign status_byte = {valid_q | snap, overrun_q, snap ? cnt_q + 6'd1 : cnt_q};

  always_comb begin
    if (state_q == StIdle) begin
      load_idx = '0;
    end else if (byte_idx_q == LastIdx) begin
      load_idx = LastIdx;
    end else begin
      load_idx = byte_idx_q + IdxW'(1);
    end
    next_byte = 8'h00;
    if (load_idx == '0) begin
      next_byte = status_byte;
    end
    for (int unsigned k = 0; k < PayBytes; k++) begin
      if (load_idx == IdxW'(k + 1)) begin
        next_byte = payload[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    cnt_d      = cnt_q;

    if (snap) begin
      buf_d   = i_X;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 6'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d    = StActive;
          shift_d    = next_byte;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
        end
      end
      StActive: begin
        if (ss_rise) begin
          state_d = StIdle;
          // Only a complete read consumes the frame; a partial one can be retried.
          if (byte_idx_q == LastIdx) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d  = '0;
            byte_idx_d = load_idx;
            shift_d    = next_byte;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
      end
    endcase

    if (i_done && (state_q == StActive)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= 6'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      cnt_q      <= cnt_d;
    end
  end

  // MSB of the status byte appears in the same cycle the SS fall is detected.
  always_comb begin
    o_miso = 1'b0;
    if (state_q == StActive) begin
      o_miso = shift_q[7];
    end else if (ss_fall) begin
      o_miso = status_byte[7];
    end
  end

  assign o_busy        = (state_q == StActive);
  assign o_frame_valid = valid_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_dft_spi_result_tx.sv
// Directed bench for dft_spi_result_tx with BIN_NUM=2: SPI mode-0 host reading result frames.
module tb_dft_spi_result_tx;

  logic                   clk;
  logic                   rst;
  logic [1:0][1:0][11:0]  x;
  logic                   done;
  logic                   ss;
  logic                   sclk;
  logic                   miso;
  logic                   frame_valid;
  logic                   busy;
  logic                   overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes [0:9];

  dft_spi_result_tx #(
    .SPI_WIDTH(8),
    .DFT_WIDTH(12),
    .BIN_NUM  (2)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst),
    .i_X          (x),
    .i_done       (done),
    .i_ss         (ss),
    .i_sclk       (sclk),
    .o_miso       (miso),
    .o_frame_valid(frame_valid),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk) done = 1'b1;
    @(negedge clk) done = 1'b0;
  endtask

  // One SCLK period; MISO sampled just before the rising edge.
  task automatic sclk_bit(output logic b);
    repeat (8) @(negedge clk);
    b    = miso;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      sclk_bit(b);
      v[i] = b;
    end
  endtask

  task automatic ss_begin();
    @(negedge clk) ss = 1'b0;
  endtask

  task automatic ss_end();
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_check(input string tag, input int first, input int n);
    logic [7:0] v;
    for (int i = first; i < first + n; i++) begin
      read_byte(v);
      check($sformatf("%s_b%0d", tag, i), v, exp_bytes[i]);
    end
  endtask

  task automatic set_frame1(input logic [7:0] status);
    exp_bytes[0] = status;
    exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h64;
    exp_bytes[3] = 8'hFF; exp_bytes[4] = 8'hFB;
    exp_bytes[5] = 8'h07; exp_bytes[6] = 8'hFF;
    exp_bytes[7] = 8'hF8; exp_bytes[8] = 8'h00;
    exp_bytes[9] = 8'h00;
  endtask

  task automatic set_frame2(input logic [7:0] status);
    exp_bytes[0] = status;
    exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'hFF;
    exp_bytes[3] = 8'h00; exp_bytes[4] = 8'h01;
    exp_bytes[5] = 8'h01; exp_bytes[6] = 8'h23;
    exp_bytes[7] = 8'hFE; exp_bytes[8] = 8'hDD;
    exp_bytes[9] = 8'h00;
  endtask

  initial begin
    logic [7:0] v;
    logic       b;
    rst  = 1'b1;
    done = 1'b0;
    ss   = 1'b1;
    sclk = 1'b0;
    x    = '0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_miso", {7'd0, miso}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_valid", {7'd0, frame_valid}, 8'd0);
    check("rst_overrun", {7'd0, overrun}, 8'd0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: snapshot and full read
    x[0][0] = 12'd100;  x[0][1] = 12'hFFB;
    x[1][0] = 12'h7FF;  x[1][1] = 12'h800;
    pulse_done();
    check("t1_valid_after_done", {7'd0, frame_valid}, 8'd1);
    set_frame1(8'h81);
    ss_begin();
    repeat (4) @(negedge clk);
    check("t1_busy", {7'd0, busy}, 8'd1);
    read_check("t1", 0, 9);
    ss_end();
    check("t1_valid_after", {7'd0, frame_valid}, 8'd0);
    check("t1_busy_after", {7'd0, busy}, 8'd0);

    // 2: re-read without new data, plus one pad byte
    set_frame1(8'h01);
    ss_begin();
    read_check("t2", 0, 10);
    ss_end();

    // 3: i_done mid-byte 3 is dropped and flags overrun
    x[0][0] = 12'hFFF;  x[0][1] = 12'h001;
    x[1][0] = 12'h123;  x[1][1] = 12'hEDD;
    set_frame1(8'h01);
    ss_begin();
    read_check("t3", 0, 3);
    for (int i = 7; i >= 4; i--) begin
      sclk_bit(b);
      v[i] = b;
    end
    pulse_done();
    for (int i = 3; i >= 0; i--) begin
      sclk_bit(b);
      v[i] = b;
    end
    check("t3_b3", v, exp_bytes[3]);
    check("t3_overrun_set", {7'd0, overrun}, 8'd1);
    read_check("t3", 4, 5);
    ss_end();
    check("t3_overrun_clr", {7'd0, overrun}, 8'd0);

    // 4: partial read keeps the frame; full re-read from byte 0
    pulse_done();
    set_frame2(8'h82);
    ss_begin();
    read_check("t4p", 0, 3);
    ss_end();
    check("t4_valid_kept", {7'd0, frame_valid}, 8'd1);
    ss_begin();
    read_check("t4", 0, 9);
    ss_end();
    check("t4_valid_after", {7'd0, frame_valid}, 8'd0);

    // 5: reset in the middle of byte 2
    pulse_done();
    set_frame2(8'h83);
    ss_begin();
    read_check("t5p", 0, 2);
    for (int i = 0; i < 3; i++) sclk_bit(b);
    repeat (8) @(negedge clk);
    rst  = 1'b1;
    ss   = 1'b1;
    sclk = 1'b0;
    #1;
    check("t5_miso", {7'd0, miso}, 8'd0);
    check("t5_busy", {7'd0, busy}, 8'd0);
    check("t5_valid", {7'd0, frame_valid}, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) exp_bytes[i] = 8'h00;
    ss_begin();
    read_check("t5", 0, 9);
    ss_end();

    // 6: counter wraps 63 -> 0
    x[0][0] = 12'd100;  x[0][1] = 12'hFFB;
    x[1][0] = 12'h7FF;  x[1][1] = 12'h800;
    for (int i = 0; i < 64; i++) pulse_done();
    set_frame1(8'h80);
    ss_begin();
    read_check("t6", 0, 9);
    ss_end();
    check("t6_valid_after", {7'd0, frame_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
